// File: rtl/alu_bool_pkg.sv
// Shared types and constants for the boolean ALU and its requester arbiter.
package alu_bool_pkg;
  localparam logic [2:0] OPCODE_XOR = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } alu_arb_state_e;
endpackage

// File: rtl/alu_bool.sv
// Boolean ALU: XOR is the only supported operation; anything else yields zero.
module alu_bool
  import alu_bool_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  opcode,
  input  logic        en,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    if (en && (opcode == OPCODE_XOR)) begin
      result = a ^ b;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int  N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

  logic            found;
  logic [ID_W:0]   scan;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    scan    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, ptr} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(N_REQ)) begin
        scan = scan - (ID_W+1)'(N_REQ);
      end
      if (en && !found && req[scan[ID_W-1:0]]) begin
        found                 = 1'b1;
        gnt[scan[ID_W-1:0]]   = 1'b1;
        gnt_idx               = scan[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_bool_arbiter.sv
// Shares one alu_bool between N_REQ requesters with round-robin issue and a single
// registered response channel.
//
//   state | meaning
//   IDLE  | arbitrate; accept one request and latch its operands
//   EXEC  | drive the ALU from latched operands, capture result/err
//   RESP  | hold response until resp_ready
module alu_bool_arbiter
  import alu_bool_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  input  logic [N_REQ*3-1:0] req_opcode,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_W-1:0]    resp_id,
  output logic [31:0]        resp_result,
  output logic               resp_err,
  output logic               busy
);

  alu_arb_state_e state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     result_q, result_d;
  logic            err_q, err_d;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic [31:0]      alu_result;
  logic             alu_en;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (state_q == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign alu_en = (state_q == EXEC);

  alu_bool u_alu_bool (
    .a      (a_q),
    .b      (b_q),
    .opcode (op_q),
    .en     (alu_en),
    .result (alu_result)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
              a_d  = req_a[32*i +: 32];
              b_d  = req_b[32*i +: 32];
              op_d = req_opcode[3*i +: 3];
            end
          end
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        err_d    = (op_q != OPCODE_XOR);
        state_d  = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign req_ready   = gnt;
  assign resp_valid  = (state_q == RESP);
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_err    = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_bool_arbiter.sv
// Directed bench for alu_bool_arbiter: reset, issue/response, round-robin order,
// backpressure, unsupported opcode and reset in flight.
module tb_alu_bool_arbiter;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*32-1:0]  req_a = '0;
  logic [N_REQ*32-1:0]  req_b = '0;
  logic [N_REQ*3-1:0]   req_opcode = '0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b0;
  logic [ID_W-1:0]      resp_id;
  logic [31:0]          resp_result;
  logic                 resp_err;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_bool_arbiter #(.N_REQ(N_REQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_opcode  (req_opcode),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
    req_a[32*i +: 32]    = a;
    req_b[32*i +: 32]    = b;
    req_opcode[3*i +: 3] = op;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL rst_resp_id: got %0d want 0", resp_id); end
    n_checks++; if (resp_result !== 32'h0) begin n_fail++; $display("FAIL rst_resp_result: got %h want 0", resp_result); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    resp_ready = 1'b1;
    set_slot(0, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'b000);
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL basic_grant: got %b want 0001", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
    @(negedge clk); #1;
    req_valid = 4'b0000;
    set_slot(0, 32'h0, 32'h0, 3'b111);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_exec_busy: got %b want 1", busy); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_exec_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL basic_exec_ready: got %b want 0000", req_ready); end
    @(negedge clk); #1;
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_resp_valid: got %b want 1", resp_valid); end
    n_checks++; if (resp_result !== 32'hF0F0_0F0F) begin n_fail++; $display("FAIL basic_result: got %h want f0f00f0f", resp_result); end
    n_checks++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL basic_id: got %0d want 0", resp_id); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", resp_err); end
    @(negedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_post_valid: got %b want 0", resp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_post_busy: got %b want 0", busy); end
  endtask

  // Starts from a fresh reset so the pointer is 0 and the order is 0,1,2,3,0.
  task automatic test_round_robin();
    logic [31:0] exp_res;
    logic [3:0]  exp_gnt;
    int          exp_id;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) set_slot(i, 32'h1111_1111 * (i + 1), 32'hFFFF_FFFF, 3'b000);
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_id  = k % N_REQ;
      exp_gnt = 4'b0001 << exp_id;
      exp_res = ~(32'h1111_1111 * (exp_id + 1));
      n_checks++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_gnt); end
      @(negedge clk); #1;
      if (k == 4) req_valid = 4'b0000;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_exec_ready[%0d]: got %b want 0000", k, req_ready); end
      @(negedge clk); #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_resp_ready[%0d]: got %b want 0000", k, req_ready); end
      n_checks++; if (resp_valid !== 1'b1 || resp_id !== ID_W'(exp_id)) begin n_fail++; $display("FAIL rr_resp_id[%0d]: got valid=%b id=%0d want valid=1 id=%0d", k, resp_valid, resp_id, exp_id); end
      n_checks++; if (resp_result !== exp_res) begin n_fail++; $display("FAIL rr_result[%0d]: got %h want %h", k, resp_result, exp_res); end
      @(negedge clk); #1;
    end
  endtask

  // Pointer is 1 here: 0100 grants 2 (ptr->3), 0101 grants 0 (ptr->1), 0101 grants 2.
  task automatic test_ptr_wrap();
    logic [3:0] masks [3] = '{4'b0100, 4'b0101, 4'b0101};
    int         ids   [3] = '{2, 0, 2};
    logic [3:0] exp_gnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = masks[k];
      exp_gnt   = 4'b0001 << ids[k];
      #1;
      n_checks++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL ptr_grant[%0d]: got %b want %b", k, req_ready, exp_gnt); end
      @(negedge clk); #1;
      req_valid = 4'b0000;
      @(negedge clk); #1;
      n_checks++; if (resp_id !== ID_W'(ids[k])) begin n_fail++; $display("FAIL ptr_resp_id[%0d]: got %0d want %0d", k, resp_id, ids[k]); end
      n_checks++; if (resp_result !== ~(32'h1111_1111 * (ids[k] + 1))) begin n_fail++; $display("FAIL ptr_result[%0d]: got %h want %h", k, resp_result, ~(32'h1111_1111 * (ids[k] + 1))); end
    end
  endtask

  // Pointer is 3: requester 3 is granted and its response is held for 5 cycles.
  task automatic test_backpressure();
    @(negedge clk);
    resp_ready = 1'b0;
    set_slot(3, 32'h1234_5678, 32'h0, 3'b000);
    req_valid = 4'b1000;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
    @(negedge clk); #1;
    req_valid = 4'b1111;
    @(negedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (resp_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got valid=%b busy=%b want 1 1", c, resp_valid, busy); end
      n_checks++; if (resp_id !== 2'd3 || resp_result !== 32'h1234_5678 || resp_err !== 1'b0) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got id=%0d res=%h err=%b want 3 12345678 0", c, resp_id, resp_result, resp_err); end
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b want 0000", c, req_ready); end
      if (c < 4) begin @(negedge clk); #1; end
    end
    resp_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: got valid=%b busy=%b want 0 0", resp_valid, busy); end
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_next_grant: got %b want 0001", req_ready); end
    req_valid = 4'b0000;
  endtask

  // Pointer is 0: requester 1 issues an unsupported opcode.
  task automatic test_bad_opcode();
    @(negedge clk);
    set_slot(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b101);
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL badop_grant: got %b want 0010", req_ready); end
    @(negedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk); #1;
    n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1) begin n_fail++; $display("FAIL badop_id: got valid=%b id=%0d want 1 1", resp_valid, resp_id); end
    n_checks++; if (resp_result !== 32'h0) begin n_fail++; $display("FAIL badop_result: got %h want 0", resp_result); end
    n_checks++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL badop_err: got %b want 1", resp_err); end
    set_slot(1, 32'h0, 32'h0, 3'b000);
  endtask

  // Pointer is 2 entering; a reset in EXEC and one in RESP must both drop the op.
  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rstmid_grant_a: got %b want 0100", req_ready); end
    @(negedge clk); #1;
    req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_exec: got valid=%b busy=%b want 0 0", resp_valid, busy); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_emit: got valid=%b busy=%b want 0 0", resp_valid, busy); end
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rstmid_grant_b: got %b want 0100", req_ready); end
    @(negedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk); #1;
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_resp_reached: got %b want 1", resp_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp: got valid=%b busy=%b want 0 0", resp_valid, busy); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_ptr_restart: got %b want 0001", req_ready); end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_ptr_wrap();
    test_backpressure();
    test_bad_opcode();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
